range_stats_finder: RTL
=======================

# range_stats_finder

Parametrised successor to the single-stream range finder. It tracks the running minimum, maximum and sample count of a gated data stream between a `go` and a `finish` strobe. On completion it publishes range, min, max and count with a one-cycle `done` pulse. Signed/unsigned compare and counter width are configurable, and protocol violations are detected and recovered from.

## Interface
- `WIDTH`, 16, data/result width in bits
- `CNT_WIDTH`, 8, sample counter width
- `SIGNED`, 0, 1 = two's-complement compare, 0 = unsigned compare
- `clock`  in  1  clock; all state changes on rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `data_in`  in  WIDTH  sample
- `valid`  in  1  `data_in` is a sample (RUN state only)
- `go`  in  1  start of sequence; `data_in` is the first sample
- `finish`  in  1  end of sequence; `data_in` is included if `valid`
- `range`  out  WIDTH  max − min, unsigned
- `res_max`  out  WIDTH  sequence maximum
- `res_min`  out  WIDTH  sequence minimum
- `count`  out  CNT_WIDTH  samples in sequence, saturating
- `done`  out  1  one-cycle pulse; results updated
- `busy`  out  1  sequence in progress
- `error`  out  1  protocol error state

## Operation
- **States:** IDLE, RUN, DONE, ERROR. Reset value is IDLE.
- **IDLE**
  - `go & !finish`: capture first sample (cur_min = cur_max = `data_in`, cur_cnt = 1), then go to RUN. `valid` is ignored.
  - `finish` (with or without `go`): go to ERROR.
  - Otherwise stay in IDLE.
- **RUN**
  - `go` (with or without `finish`): go to ERROR. The cycle's sample is discarded and results are not updated.
  - `finish & !go`: compute final_min/final_max/final_cnt including `data_in` if `valid`. Register them into `res_min`, `res_max`, `count`, and register `range = final_max − final_min`. Go to DONE.
  - `valid` alone: cur_min ← min(cur_min, `data_in`), cur_max ← max(cur_max, `data_in`), cur_cnt ← cur_cnt + 1 (saturating at 2^CNT_WIDTH − 1).
  - Otherwise hold.
- **DONE**
  - `done` = 1 for this single cycle. Next state is IDLE unconditionally; `go` in DONE is ignored.
- **ERROR**
  - `error` = 1.
  - `go & !finish`: capture the first sample exactly as in IDLE and go to RUN.
  - Otherwise stay in ERROR.
- **Compare mode:** SIGNED=1 uses signed compare. `range` is always the WIDTH-bit unsigned difference; this is exact for both modes.
- **Result hold:** result registers hold their value until the next RUN→DONE transition. Error sequences never modify them.
- **Output decodes:** `busy` = (state == RUN). `done` and `error` are decoded from registered state, so they are glitch-free.

## Timing
- **Reset values:** `range`, `res_max`, `res_min`, `count` = 0; `done`, `busy`, `error` = 0; state = IDLE. Internal cur_* registers = 0.
- **Asynchronous reset mid-sequence:** immediately returns to IDLE with all outputs 0. The partial sequence is discarded.
- **Latency:** `finish` sampled at edge t. At t+1, `done` = 1 and the results are valid and stable. At t+2, `done` = 0 and the state is IDLE.
- **Throughput:** minimum sequence is `go` at t, `finish` at t+1. The next `go` is accepted 2 cycles after `finish`, i.e. once back in IDLE.
- **Min/max update:** same-cycle visible. A sample on the `finish` cycle participates in the result.
- **Counter saturation:** `count` stays at 2^CNT_WIDTH − 1; there is no wrap.

## Structure
- **Package `range_pkg`:**
  - state enum `rs_state_t` (logic [1:0]: IDLE, RUN, DONE, ERROR)
  - function `rs_less(a, b, signed_mode)` shared by compare logic
- **Sub-module `minmax_tracker`:**
  - contains cur_min/cur_max/cur_cnt registers, `init`/`update` enables, and combinational final_* outputs
  - parametrised by WIDTH, CNT_WIDTH, SIGNED
- **Top level:** FSM and result registers only.

## Test plan
- **Basic unsigned, WIDTH=16:** `go` with 10, valid 3, 250, 7, then `finish` with valid 40 → `done` one cycle later; `res_min` = 3, `res_max` = 250, `range` = 247, `count` = 5.
- **SIGNED=1:** `go` with 0xFFFB (−5), valid 0x0007, `finish` with valid=0 → `res_min` = 0xFFFB, `res_max` = 7, `range` = 12, `count` = 2.
- **Protocol errors:**
  - `go` asserted again mid-RUN → `error` = 1 next cycle and results unchanged from the previous sequence.
  - `finish` in IDLE → ERROR.
  - `go & !finish` in ERROR with 9, then `finish` → `res_min` = `res_max` = 9, `range` = 0, `count` = 1.
- **Saturation, CNT_WIDTH=4:** 20 valid samples → `count` = 15.
- **Reset mid-sequence:** asynchronous `reset` pulsed between clock edges during RUN → all outputs 0 immediately; next `go` starts a clean sequence.
- **Back-to-back sequences:** second `go` two cycles after `finish` accepted; `go` during DONE ignored.

Source files
------------

// File: rtl/range_stats_finder_pkg.sv
// Shared types and compare helper for the range_stats_finder block.
package range_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } rs_state_t;

    // Operands are widened to this width before comparing, so WIDTH may be at most 64.
    localparam int RS_CMP_W = 64;

    // a < b, either as two's-complement or as unsigned values.
    function automatic logic rs_less(input logic [RS_CMP_W-1:0] a,
                                     input logic [RS_CMP_W-1:0] b,
                                     input logic                signed_mode);
        if (signed_mode) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

endpackage

// File: rtl/range_stats_finder_if.sv
// Sample stream in, published statistics out.
interface range_stats_finder_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     data_in;
    logic                 valid;
    logic                 go;
    logic                 finish;
    logic [WIDTH-1:0]     range;
    logic [WIDTH-1:0]     res_max;
    logic [WIDTH-1:0]     res_min;
    logic [CNT_WIDTH-1:0] count;
    logic                 done;
    logic                 busy;
    logic                 error;

    modport master (
        output data_in, valid, go, finish,
        input  range, res_max, res_min, count, done, busy, error
    );

    modport slave (
        input  data_in, valid, go, finish,
        output range, res_max, res_min, count, done, busy, error
    );
endinterface

// File: rtl/range_stats_finder_minmax_tracker.sv
// Running min/max/count of the current sequence. final_* show what the
// registers would become if this cycle's sample (when valid) were merged.
module minmax_tracker
    import range_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8,
    parameter int SIGNED    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 update,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 valid,
    output logic [WIDTH-1:0]     final_min,
    output logic [WIDTH-1:0]     final_max,
    output logic [CNT_WIDTH-1:0] final_cnt
);

    logic [WIDTH-1:0]     min_q, min_d;
    logic [WIDTH-1:0]     max_q, max_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 below_min;
    logic                 above_max;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Sign- or zero-extend so one comparator serves both compare modes.
    function automatic logic [RS_CMP_W-1:0] widen(input logic [WIDTH-1:0] v);
        logic [RS_CMP_W-1:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        if (SIGNED != 0) begin
            for (int i = WIDTH; i < RS_CMP_W; i++) begin
                r[i] = v[WIDTH-1];
            end
        end
        return r;
    endfunction

    // Merge the current sample into the running values; count saturates.
    always_comb begin
        below_min = rs_less(widen(data_in), widen(min_q), SIGNED != 0);
        above_max = rs_less(widen(max_q), widen(data_in), SIGNED != 0);
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        final_min = (valid && below_min) ? data_in : min_q;
        final_max = (valid && above_max) ? data_in : max_q;
        final_cnt = valid ? cnt_inc : cnt_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        if (init) begin
            min_d = data_in;
            max_d = data_in;
            cnt_d = CNT_WIDTH'(1);
        end else if (update) begin
            min_d = final_min;
            max_d = final_max;
            cnt_d = final_cnt;
        end
    end

    // Running-value registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/range_stats_finder.sv
// Sequence controller: go/finish protocol FSM and published result registers.
module range_stats_finder
    import range_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8,
    parameter int SIGNED    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    range_stats_finder_if.slave  bus
);

    rs_state_t            state_q;
    logic [WIDTH-1:0]     range_q;
    logic [WIDTH-1:0]     res_min_q;
    logic [WIDTH-1:0]     res_max_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 error_q;

    logic                 trk_init;
    logic                 trk_update;
    logic [WIDTH-1:0]     final_min;
    logic [WIDTH-1:0]     final_max;
    logic [CNT_WIDTH-1:0] final_cnt;

    // A lone go starts a sequence from IDLE or ERROR; a lone valid extends one in RUN.
    always_comb begin
        trk_init   = (state_q == IDLE || state_q == ERROR) && bus.go && !bus.finish;
        trk_update = (state_q == RUN) && bus.valid && !bus.go && !bus.finish;
    end

    minmax_tracker #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .SIGNED    (SIGNED)
    ) u_tracker (
        .clock     (clock),
        .reset     (reset),
        .init      (trk_init),
        .update    (trk_update),
        .data_in   (bus.data_in),
        .valid     (bus.valid),
        .final_min (final_min),
        .final_max (final_max),
        .final_cnt (final_cnt)
    );

    // Protocol FSM; status flags are registered alongside the state they decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            range_q   <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.finish) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else if (bus.go) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.go) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else if (bus.finish) begin
                        res_min_q <= final_min;
                        res_max_q <= final_max;
                        count_q   <= final_cnt;
                        range_q   <= final_max - final_min;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERROR: begin
                    if (bus.go && !bus.finish) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.range   = range_q;
    assign bus.res_min = res_min_q;
    assign bus.res_max = res_max_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.error   = error_q;

endmodule
